// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with tenure-based preemption, lock hold-off,
// fixed turnaround gap and alternating tie-break between masters.
module bus_arbiter #(
   parameter int MAX_TEN  = 16,
   parameter int TURN_CYC = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BR0,
   input  logic       LOCK0,
   output logic       BA0,
   input  logic       BR1,
   input  logic       LOCK1,
   output logic       BA1,
   output logic [1:0] OWNER,
   output logic       TMO
);

   typedef enum logic [1:0] {
      IDLE,
      GNT0,
      GNT1,
      TURN
   } state_t;

   localparam logic [7:0] TEN_LIM   = 8'(MAX_TEN - 1);
   localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);

   state_t     state_q, state_d;
   logic [7:0] ten_q, ten_d;
   logic [3:0] turn_q, turn_d;
   logic       last_q, last_d;
   logic       ba0_q, ba0_d;
   logic       ba1_q, ba1_d;
   logic [1:0] owner_q, owner_d;
   logic       tmo_q, tmo_d;

   logic       grab;
   logic       pick;
   logic       cur;
   logic       own_br;
   logic       oth_br;
   logic       own_lk;
   logic       preempt;

   always_comb begin
      grab    = BR0 | BR1;
      // pick = 1 selects master 1; a tie goes to whoever was not last
      pick    = (BR0 & BR1) ? ~last_q : BR1;
      cur     = (state_q == GNT1);
      own_br  = cur ? BR1 : BR0;
      oth_br  = cur ? BR0 : BR1;
      own_lk  = cur ? LOCK1 : LOCK0;
      preempt = own_br & oth_br & ~own_lk & (ten_q >= TEN_LIM);

      state_d = state_q;
      ten_d   = ten_q;
      turn_d  = turn_q;
      last_d  = last_q;
      tmo_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (grab) begin
               state_d = pick ? GNT1 : GNT0;
               ten_d   = 8'd0;
               last_d  = pick;
            end
         end
         GNT0, GNT1: begin
            if (!own_br || preempt) begin
               state_d = TURN;
               turn_d  = 4'd0;
               tmo_d   = own_br;
            end else if (ten_q != 8'hff) begin
               ten_d = ten_q + 8'd1;
            end
         end
         TURN: begin
            if (turn_q == TURN_LAST) begin
               turn_d = 4'd0;
               if (grab) begin
                  state_d = pick ? GNT1 : GNT0;
                  ten_d   = 8'd0;
                  last_d  = pick;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               turn_d = turn_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      ba0_d   = (state_d == GNT0);
      ba1_d   = (state_d == GNT1);
      owner_d = {ba1_d, ba0_d};
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         ten_q   <= 8'd0;
         turn_q  <= 4'd0;
         last_q  <= 1'b1;
         ba0_q   <= 1'b0;
         ba1_q   <= 1'b0;
         owner_q <= 2'b00;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ten_q   <= ten_d;
         turn_q  <= turn_d;
         last_q  <= last_d;
         ba0_q   <= ba0_d;
         ba1_q   <= ba1_d;
         owner_q <= owner_d;
         tmo_q   <= tmo_d;
      end
   end

   assign BA0   = ba0_q;
   assign BA1   = ba1_q;
   assign OWNER = owner_q;
   assign TMO   = tmo_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter (MAX_TEN=4, TURN_CYC=1)
// followed by a random phase checking the output invariants.
module tb_bus_arbiter;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       BR0 = 1'b0;
   logic       LOCK0 = 1'b0;
   logic       BR1 = 1'b0;
   logic       LOCK1 = 1'b0;
   logic       BA0;
   logic       BA1;
   logic [1:0] OWNER;
   logic       TMO;

   int n_assert = 0;
   int n_fail   = 0;

   logic [4:0] exp_q[$];
   string      tag_q[$];

   bus_arbiter #(
      .MAX_TEN (4),
      .TURN_CYC(1)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .BR0  (BR0),
      .LOCK0(LOCK0),
      .BA0  (BA0),
      .BR1  (BR1),
      .LOCK1(LOCK1),
      .BA1  (BA1),
      .OWNER(OWNER),
      .TMO  (TMO)
   );

   always #5 CLK = ~CLK;

   // Drive one cycle of inputs, queue the outputs expected after the
   // sampling edge, then pop and compare once that edge has passed.
   task automatic step(input logic rst, input logic b0, input logic l0,
                       input logic b1, input logic l1,
                       input logic e0, input logic e1,
                       input logic [1:0] eo, input logic et,
                       input string tag);
      logic [4:0] exp;
      logic [4:0] obs;
      string      t;
      RST   = rst;
      BR0   = b0;
      LOCK0 = l0;
      BR1   = b1;
      LOCK1 = l1;
      exp_q.push_back({e0, e1, eo, et});
      tag_q.push_back(tag);
      @(posedge CLK);
      #1;
      exp = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {BA0, BA1, OWNER, TMO};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed ba0,ba1,owner,tmo=%b expected %b",
                t, obs, exp);
      end
   endtask

   initial begin
      logic prev_tmo;
      logic r, b0, l0, b1, l1;

      // reset state
      step(0, 0,0, 0,0, 0,0,2'b00,0, "reset");

      // single request, release, one turnaround cycle
      step(1, 1,0, 0,0, 1,0,2'b01,0, "grant0");
      step(1, 1,0, 0,0, 1,0,2'b01,0, "hold0");
      step(1, 0,0, 0,0, 0,0,2'b00,0, "rel0_turn");
      step(1, 0,0, 0,0, 0,0,2'b00,0, "idle0");
      step(1, 0,1, 0,1, 0,0,2'b00,0, "idle_lock_ign");

      // tie on first post-reset edge goes to master 0
      step(0, 0,0, 0,0, 0,0,2'b00,0, "reset2");
      step(1, 1,0, 1,0, 1,0,2'b01,0, "tie_first0");
      step(1, 0,0, 1,0, 0,0,2'b00,0, "rel0_tie");
      step(1, 0,0, 1,0, 0,1,2'b10,0, "gnt1_after_turn");
      step(1, 0,0, 0,0, 0,0,2'b00,0, "rel1_turn");
      step(1, 0,0, 0,0, 0,0,2'b00,0, "idle1");

      // tenure preemption after 4 grant cycles
      step(1, 1,0, 0,0, 1,0,2'b01,0, "pre_c1");
      step(1, 1,0, 1,0, 1,0,2'b01,0, "pre_c2");
      step(1, 1,0, 1,0, 1,0,2'b01,0, "pre_c3");
      step(1, 1,0, 1,0, 1,0,2'b01,0, "pre_c4");
      step(1, 1,0, 1,0, 0,0,2'b00,1, "preempt_tmo");
      step(1, 1,0, 1,0, 0,1,2'b10,0, "fair_gnt1");
      step(1, 1,0, 0,0, 0,0,2'b00,0, "rel1_b");
      step(1, 1,0, 0,0, 1,0,2'b01,0, "regrant0");

      // lock holds off preemption well past the tenure limit
      for (int i = 0; i < 9; i++)
         step(1, 1,1, 1,0, 1,0,2'b01,0, "locked_hold");
      step(1, 1,0, 1,0, 0,0,2'b00,1, "lock_drop_tmo");
      step(1, 1,0, 1,0, 0,1,2'b10,0, "fair_after_lock");

      // reset mid-grant, then master 0 wins the tie
      step(0, 1,0, 1,0, 0,0,2'b00,0, "rst_mid_gnt");
      step(1, 1,0, 1,0, 1,0,2'b01,0, "after_rst_tie0");

      // no preemption without a competing request
      for (int i = 0; i < 8; i++)
         step(1, 1,0, 0,0, 1,0,2'b01,0, "no_compete");

      // reset in the middle of a turnaround
      step(1, 0,0, 0,0, 0,0,2'b00,0, "turn_b");
      step(0, 1,0, 1,0, 0,0,2'b00,0, "rst_mid_turn");
      step(1, 0,0, 1,0, 0,1,2'b10,0, "after_rst_g1");

      // random traffic with invariant checks
      prev_tmo = 1'b0;
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(0, 49) != 0);
         b0 = $urandom_range(0, 3) != 0;
         b1 = $urandom_range(0, 3) != 0;
         l0 = $urandom_range(0, 2) == 0;
         l1 = $urandom_range(0, 2) == 0;
         RST = r;
         BR0 = b0;
         LOCK0 = l0;
         BR1 = b1;
         LOCK1 = l1;
         @(posedge CLK);
         #1;
         n_assert++;
         assert (!(BA0 && BA1)) else begin
            n_fail++;
            $error("FAIL rnd_excl: observed ba0=%b ba1=%b expected not both",
                   BA0, BA1);
         end
         n_assert++;
         assert (OWNER === {BA1, BA0}) else begin
            n_fail++;
            $error("FAIL rnd_owner: observed %b expected %b",
                   OWNER, {BA1, BA0});
         end
         n_assert++;
         assert (!(TMO && prev_tmo)) else begin
            n_fail++;
            $error("FAIL rnd_tmo: observed tmo high twice expected single");
         end
         prev_tmo = TMO;
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
